// File: rtl/boid_frame_writer_pkg.sv
// Shared frame-buffer geometry, boid coordinate widths and writer FSM encoding,
// used by the frame writer, the VGA reader and the boid update logic.
package boid_frame_writer_pkg;

  localparam int FB_WIDTH   = 320;
  localparam int FB_HEIGHT  = 240;
  localparam int ADDR_WIDTH = 19;
  localparam int BOID_X_W   = 9;
  localparam int BOID_Y_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    LATCH,
    PLOT,
    DONE
  } fb_state_t;

  // A single-boid build still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boid_frame_writer_rising_edge.sv
// Registered rising-edge detector for the screenEnd level coming from the pixel-clock domain.
module fb_rising_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  // level_q resets high so a level held through reset release is not seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b1;
      rise    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

endmodule

// File: rtl/boid_frame_writer.sv
// Per frame: clears the whole frame buffer to 0, then fetches each boid position and
// plots a BOID_SIZE x BOID_SIZE square of 1s, clipping pixels that fall off the screen.
module boid_frame_writer #(
  parameter int NUM_BOIDS  = 16,
  parameter int FB_WIDTH   = boid_frame_writer_pkg::FB_WIDTH,
  parameter int FB_HEIGHT  = boid_frame_writer_pkg::FB_HEIGHT,
  parameter int ADDR_WIDTH = boid_frame_writer_pkg::ADDR_WIDTH,
  parameter int BOID_SIZE  = 2
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   screenEnd,
  output logic [boid_frame_writer_pkg::idx_width(NUM_BOIDS)-1:0] boid_index,
  input  logic [boid_frame_writer_pkg::BOID_X_W-1:0]             boid_x,
  input  logic [boid_frame_writer_pkg::BOID_Y_W-1:0]             boid_y,
  output logic                                                   wr_en,
  output logic [ADDR_WIDTH-1:0]                                  wr_address,
  output logic                                                   wr_data,
  output logic                                                   busy,
  output logic                                                   frame_done,
  output logic                                                   overrun
);
  import boid_frame_writer_pkg::*;

  localparam int IW = idx_width(NUM_BOIDS);
  localparam int SW = $clog2(BOID_SIZE + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);
  localparam logic [SW-1:0]         LAST_D    = SW'(BOID_SIZE - 1);
  localparam logic [IW-1:0]         LAST_IDX  = IW'(NUM_BOIDS - 1);

  fb_state_t             state;
  logic                  start;
  logic [BOID_X_W-1:0]   bx;
  logic [BOID_Y_W-1:0]   by;
  logic [SW-1:0]         dx, dy, ndx, ndy;
  logic [ADDR_WIDTH-1:0] px, py, pix_addr;
  logic                  pix_ok;

  fb_rising_edge u_edge (
    .clk   (clk),
    .reset (reset),
    .level (screenEnd),
    .rise  (start)
  );

  assign busy = (state != IDLE);

  // Pixel issued on the next edge: (0,0) straight off the read port in LATCH,
  // otherwise the successor of the current (dx,dy) with dx running fastest.
  always_comb begin
    ndx = '0;
    ndy = '0;
    px  = ADDR_WIDTH'(boid_x);
    py  = ADDR_WIDTH'(boid_y);
    if (state == PLOT) begin
      px = ADDR_WIDTH'(bx);
      py = ADDR_WIDTH'(by);
      if (dx == LAST_D) begin
        ndy = dy + 1'b1;
      end else begin
        ndx = dx + 1'b1;
        ndy = dy;
      end
    end
    px       = px + ADDR_WIDTH'(ndx);
    py       = py + ADDR_WIDTH'(ndy);
    pix_ok   = (px < ADDR_WIDTH'(FB_WIDTH)) && (py < ADDR_WIDTH'(FB_HEIGHT));
    pix_addr = px + ADDR_WIDTH'(FB_WIDTH) * py;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= 1'b0;
      boid_index <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      bx         <= '0;
      by         <= '0;
      dx         <= '0;
      dy         <= '0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= start && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            state      <= CLEAR;
            wr_en      <= 1'b1;
            wr_data    <= 1'b0;
            wr_address <= '0;
            boid_index <= '0;
          end
        end
        CLEAR: begin
          if (wr_address == LAST_ADDR) begin
            state <= FETCH;
            wr_en <= 1'b0;
          end else begin
            wr_address <= wr_address + 1'b1;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          bx         <= boid_x;
          by         <= boid_y;
          dx         <= '0;
          dy         <= '0;
          wr_en      <= pix_ok;
          wr_data    <= 1'b1;
          wr_address <= pix_addr;
          state      <= PLOT;
        end
        PLOT: begin
          if (dx == LAST_D && dy == LAST_D) begin
            wr_en <= 1'b0;
            if (boid_index == LAST_IDX) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              boid_index <= boid_index + 1'b1;
              state      <= FETCH;
            end
          end else begin
            dx         <= ndx;
            dy         <= ndy;
            wr_en      <= pix_ok;
            wr_address <= pix_addr;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boid_frame_writer.sv
// Directed bench: a 1-boid and a 16-boid writer on a 32x24 frame buffer, checked
// against hand-computed write sequences and frame latencies.
module tb_boid_frame_writer;

  localparam int W = 32;
  localparam int H = 24;
  localparam int NPIX = W * H;
  localparam int LAT_A = NPIX + 1 * 6 + 1;   // 775
  localparam int LAT_B = NPIX + 16 * 6 + 1;  // 865

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  se, wen, wdat, busy, fdone, ovr;
  logic [18:0] wa [2];
  logic [8:0]  bxin [2];
  logic [7:0]  byin [2];
  logic [0:0]  idx_a;
  logic [3:0]  idx_b;
  logic [8:0]  pos_x;
  logic [7:0]  pos_y;
  logic [8:0]  tx [16];
  logic [7:0]  ty [16];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int t0;
  int zexp[2], zcnt[2], zerr[2], zfirst[2], zlast[2], wcnt[2], dcnt[2], dcyc[2], ocnt[2];
  logic [18:0] ones_a[$];
  logic [18:0] ones_b[$];

  boid_frame_writer #(.NUM_BOIDS(1), .FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_WIDTH(19), .BOID_SIZE(2)) dut_a (
    .clk(clk), .reset(rst), .screenEnd(se[0]), .boid_index(idx_a), .boid_x(bxin[0]), .boid_y(byin[0]),
    .wr_en(wen[0]), .wr_address(wa[0]), .wr_data(wdat[0]), .busy(busy[0]), .frame_done(fdone[0]),
    .overrun(ovr[0]));

  boid_frame_writer #(.NUM_BOIDS(16), .FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_WIDTH(19), .BOID_SIZE(2)) dut_b (
    .clk(clk), .reset(rst), .screenEnd(se[1]), .boid_index(idx_b), .boid_x(bxin[1]), .boid_y(byin[1]),
    .wr_en(wen[1]), .wr_address(wa[1]), .wr_data(wdat[1]), .busy(busy[1]), .frame_done(fdone[1]),
    .overrun(ovr[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Boid position memories with one-cycle read latency.
  always @(posedge clk) begin
    bxin[0] <= pos_x;
    byin[0] <= pos_y;
    bxin[1] <= tx[idx_b];
    byin[1] <= ty[idx_b];
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wen[d] === 1'b1) begin
        wcnt[d]++;
        if (wdat[d] === 1'b0) begin
          if (wa[d] !== 19'(zexp[d])) zerr[d]++;
          if (zcnt[d] == 0) zfirst[d] = cyc;
          zlast[d] = cyc;
          zexp[d]++;
          zcnt[d]++;
        end else if (d == 0) ones_a.push_back(wa[d]);
        else ones_b.push_back(wa[d]);
      end
      if (fdone[d] === 1'b1) begin
        dcnt[d]++;
        dcyc[d] = cyc;
      end
      if (ovr[d] === 1'b1) ocnt[d]++;
    end
  end

  function automatic void clear_mon();
    for (int d = 0; d < 2; d++) begin
      zexp[d] = 0; zcnt[d] = 0; zerr[d] = 0; zfirst[d] = 0; zlast[d] = 0;
      wcnt[d] = 0; dcnt[d] = 0; dcyc[d] = 0; ocnt[d] = 0;
    end
    ones_a.delete();
    ones_b.delete();
  endfunction

  // Four-cycle screenEnd pulse; t0 is the cycle in which the registered edge is high.
  task automatic pulse(input int d);
    @(posedge clk); #1 se[d] = 1'b1;
    @(posedge clk); #1 t0 = cyc;
    repeat (3) @(posedge clk);
    #1 se[d] = 1'b0;
  endtask

  task automatic wait_frame(input int d);
    for (int i = 0; i < 3000 && dcnt[d] == 0; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; se = 2'b00; pos_x = '0; pos_y = '0;
    for (int i = 0; i < 16; i++) begin tx[i] = '0; ty[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (wen !== 2'b00) begin n_fail++; $display("FAIL reset_wr_en got %b want 00", wen); end
    n_checks++; if (wdat !== 2'b00) begin n_fail++; $display("FAIL reset_wr_data got %b want 00", wdat); end
    n_checks++; if (busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy got %b want 00", busy); end
    n_checks++; if ({fdone, ovr} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses got %b want 0000", {fdone, ovr}); end
    n_checks++; if (wa[0] !== 19'd0 || wa[1] !== 19'd0) begin n_fail++; $display("FAIL reset_addr got %0d/%0d want 0/0", wa[0], wa[1]); end
    n_checks++; if (idx_a !== 1'b0 || idx_b !== 4'd0) begin n_fail++; $display("FAIL reset_index got %0d/%0d want 0/0", idx_a, idx_b); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_boid();
    logic [18:0] e [4];
    e = '{19'd170, 19'd171, 19'd202, 19'd203};
    clear_mon(); pos_x = 9'd10; pos_y = 8'd5;
    pulse(0); wait_frame(0);
    n_checks++; if (zcnt[0] != NPIX) begin n_fail++; $display("FAIL single_zero_count got %0d want %0d", zcnt[0], NPIX); end
    n_checks++; if (zerr[0] != 0) begin n_fail++; $display("FAIL single_zero_order got %0d bad want 0", zerr[0]); end
    n_checks++; if (zlast[0] - zfirst[0] != NPIX - 1) begin n_fail++; $display("FAIL single_zero_gaps got span %0d want %0d", zlast[0] - zfirst[0], NPIX - 1); end
    n_checks++; if (zfirst[0] - t0 != 1) begin n_fail++; $display("FAIL single_first_write got %0d want 1", zfirst[0] - t0); end
    n_checks++; if (ones_a.size() != 4) begin n_fail++; $display("FAIL single_ones_count got %0d want 4", ones_a.size()); end
    for (int i = 0; i < 4 && i < ones_a.size(); i++) begin
      n_checks++; if (ones_a[i] !== e[i]) begin n_fail++; $display("FAIL single_one_addr[%0d] got %0d want %0d", i, ones_a[i], e[i]); end
    end
    n_checks++; if (dcyc[0] - t0 != LAT_A) begin n_fail++; $display("FAIL single_latency got %0d want %0d", dcyc[0] - t0, LAT_A); end
    n_checks++; if (dcnt[0] != 1 || ocnt[0] != 0) begin n_fail++; $display("FAIL single_done_ovr got %0d/%0d want 1/0", dcnt[0], ocnt[0]); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %b want 0", busy[0]); end
  endtask

  task automatic test_clip();
    clear_mon(); pos_x = 9'd31; pos_y = 8'd23;
    pulse(0); wait_frame(0);
    n_checks++; if (ones_a.size() != 1) begin n_fail++; $display("FAIL clip_ones_count got %0d want 1", ones_a.size()); end
    if (ones_a.size() > 0) begin
      n_checks++; if (ones_a[0] !== 19'd767) begin n_fail++; $display("FAIL clip_addr got %0d want 767", ones_a[0]); end
    end
    n_checks++; if (wcnt[0] != NPIX + 1) begin n_fail++; $display("FAIL clip_total_writes got %0d want %0d", wcnt[0], NPIX + 1); end
    n_checks++; if (dcyc[0] - t0 != LAT_A) begin n_fail++; $display("FAIL clip_latency got %0d want %0d", dcyc[0] - t0, LAT_A); end
  endtask

  task automatic test_overrun();
    clear_mon(); pos_x = 9'd10; pos_y = 8'd5;
    pulse(0);
    repeat (100) @(posedge clk);
    pulse(0); wait_frame(0);
    n_checks++; if (ocnt[0] != 1) begin n_fail++; $display("FAIL overrun_count got %0d want 1", ocnt[0]); end
    n_checks++; if (zcnt[0] != NPIX || zerr[0] != 0) begin n_fail++; $display("FAIL overrun_clear got %0d writes %0d bad want %0d/0", zcnt[0], zerr[0], NPIX); end
    n_checks++; if (dcnt[0] != 1) begin n_fail++; $display("FAIL overrun_done_count got %0d want 1", dcnt[0]); end
    n_checks++; if (ones_a.size() != 4) begin n_fail++; $display("FAIL overrun_ones got %0d want 4", ones_a.size()); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int snap;
    clear_mon();
    pulse(0);
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (wen[0] === 1'b1 && wa[0] === 19'd400) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL midreset_reach got 0 want 1"); end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    n_checks++; if (wen[0] !== 1'b0) begin n_fail++; $display("FAIL midreset_async_wr_en got %b want 0", wen[0]); end
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy[0]); end
    snap = wcnt[0];
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    n_checks++; if (wcnt[0] != snap) begin n_fail++; $display("FAIL midreset_no_writes got %0d want %0d", wcnt[0], snap); end
    clear_mon(); pos_x = 9'd10; pos_y = 8'd5;
    pulse(0); wait_frame(0);
    n_checks++; if (zcnt[0] != NPIX || zerr[0] != 0) begin n_fail++; $display("FAIL midreset_restart got %0d writes %0d bad want %0d/0", zcnt[0], zerr[0], NPIX); end
    n_checks++; if (dcnt[0] != 1) begin n_fail++; $display("FAIL midreset_done got %0d want 1", dcnt[0]); end
  endtask

  task automatic test_held_high();
    rst = 1'b1; se[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL held_busy got %b want 0", busy[0]); end
    n_checks++; if (wcnt[0] != 0) begin n_fail++; $display("FAIL held_writes got %0d want 0", wcnt[0]); end
    se[0] = 1'b0;
    repeat (2) @(posedge clk);
    clear_mon(); pos_x = 9'd10; pos_y = 8'd5;
    pulse(0); wait_frame(0);
    n_checks++; if (dcnt[0] != 1) begin n_fail++; $display("FAIL held_then_pulse_done got %0d want 1", dcnt[0]); end
    n_checks++; if (dcyc[0] - t0 != LAT_A) begin n_fail++; $display("FAIL held_then_pulse_latency got %0d want %0d", dcyc[0] - t0, LAT_A); end
  endtask

  task automatic test_all_origin();
    logic [18:0] pat [4];
    pat = '{19'd0, 19'd1, 19'd32, 19'd33};
    for (int i = 0; i < 16; i++) begin tx[i] = '0; ty[i] = '0; end
    clear_mon();
    pulse(1); wait_frame(1);
    n_checks++; if (ones_b.size() != 64) begin n_fail++; $display("FAIL origin_ones_count got %0d want 64", ones_b.size()); end
    for (int i = 0; i < 64 && i < ones_b.size(); i++) begin
      n_checks++; if (ones_b[i] !== pat[i % 4]) begin n_fail++; $display("FAIL origin_addr[%0d] got %0d want %0d", i, ones_b[i], pat[i % 4]); end
    end
    n_checks++; if (dcyc[1] - t0 != LAT_B) begin n_fail++; $display("FAIL origin_latency got %0d want %0d", dcyc[1] - t0, LAT_B); end
    n_checks++; if (zcnt[1] != NPIX || zerr[1] != 0) begin n_fail++; $display("FAIL origin_clear got %0d writes %0d bad want %0d/0", zcnt[1], zerr[1], NPIX); end
  endtask

  // Distinct boids (2i, i) with the last one in the corner, then two frames back to back.
  task automatic test_back_to_back();
    logic [18:0] exp_q[$];
    int x, y;
    for (int i = 0; i < 16; i++) begin tx[i] = 9'(2 * i); ty[i] = 8'(i); end
    tx[15] = 9'd31; ty[15] = 8'd23;
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 4; k++) begin
        x = int'(tx[i]) + k % 2;
        y = int'(ty[i]) + k / 2;
        if (x < W && y < H) exp_q.push_back(19'(x + W * y));
      end
    for (int f = 0; f < 2; f++) begin
      clear_mon();
      pulse(1); wait_frame(1);
      n_checks++; if (ones_b.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b%0d_ones_count got %0d want %0d", f, ones_b.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < ones_b.size(); i++) begin
        n_checks++; if (ones_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b%0d_addr[%0d] got %0d want %0d", f, i, ones_b[i], exp_q[i]); end
      end
      n_checks++; if (dcyc[1] - t0 != LAT_B || dcnt[1] != 1) begin n_fail++; $display("FAIL b2b%0d_done got lat %0d cnt %0d want %0d/1", f, dcyc[1] - t0, dcnt[1], LAT_B); end
    end
  endtask

  initial begin
    rst = 1'b1;
    se = 2'b00;
    clear_mon();
    test_reset();
    test_single_boid();
    test_clip();
    test_overrun();
    test_reset_mid();
    test_held_high();
    test_all_origin();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
